ysyx_22050243_mem_arb: RTL and testbench
========================================

YSYX_22050243_MEM_ARB -- requirements
Module: ysyx_22050243_mem_arb

Interface
REQ-001 Parameter FAIR, default 1, SHALL select round-robin tie-break (1) or fixed load/store priority (0).
REQ-002 Parameter TIMEOUT_CYC, default 255, SHALL set the watchdog limit in cycles; 0 disables it.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 if_req  in  1  fetch request; held high with stable if_addr until if_rvalid.
REQ-006 if_addr  in  64  fetch byte address, 4-byte aligned.
REQ-007 if_rdata  out  32  fetched instruction.
REQ-008 if_rvalid  out  1  fetch complete, one-cycle pulse.
REQ-009 ls_req  in  1  load/store request; held high with stable ls_* inputs until ls_rvalid.
REQ-010 ls_we  in  1  1 = store, 0 = load.
REQ-011 ls_addr  in  64  data address, 8-byte aligned.
REQ-012 ls_wdata  in  64  store data.
REQ-013 ls_wmask  in  8  store byte enables.
REQ-014 ls_rdata  out  64  load data.
REQ-015 ls_rvalid  out  1  load/store complete, one-cycle pulse.
REQ-016 mem_valid  out  1  memory request valid.
REQ-017 mem_ready  in  1  memory accepts request.
REQ-018 mem_we, mem_addr, mem_wdata, mem_wmask  out  1/64/64/8  memory request fields.
REQ-019 mem_rvalid  in  1  memory response valid; mem_rdata  in  64  response data.
REQ-020 if_stall, ls_stall  out  1  stall to pipeline; err  out  1  watchdog timeout pulse.

Function
REQ-021 FSM states: IDLE, REQ, RESP; plus owner (IF/LS) and last_owner registers.
REQ-022 IDLE: if any request is pending, latch the winner's fields into mem_* registers, set owner, go to REQ next cycle; mem_valid SHALL be 0 in IDLE.
REQ-023 Tie (if_req and ls_req both high in IDLE): FAIR=1 grants the requester that is not last_owner; FAIR=0 always grants LS.
REQ-024 Fetch grant: mem_we=0, mem_wmask=0, mem_wdata=0, mem_addr=if_addr.
REQ-025 REQ: mem_valid=1 with fields stable; on mem_ready=1 go to RESP and set last_owner=owner.
REQ-026 RESP: mem_valid=0; on mem_rvalid=1 pulse the owner's rvalid combinationally in the same cycle, go to IDLE.
REQ-027 if_rdata SHALL be mem_rdata[63:32] when if_addr[2]=1, else mem_rdata[31:0]; ls_rdata=mem_rdata; both valid only while the matching rvalid is high.
REQ-028 Stores SHALL complete on mem_rvalid exactly as loads do; ls_rdata is don't-care for stores.
REQ-029 if_stall = if_req & ~if_rvalid; ls_stall = ls_req & ~ls_rvalid, both combinational.
REQ-030 Minimum latency: request in IDLE at cycle 0, mem_ready at cycle 1, mem_rvalid at cycle 2 -> rvalid at cycle 2; the next request is accepted in IDLE at cycle 3.
REQ-031 Only one transaction SHALL be outstanding; the other requester waits with its stall high.
REQ-032 A request dropped after grant SHALL still complete on the memory side; the rvalid pulse still occurs.
REQ-033 Watchdog: a 16-bit counter clears on entering REQ and increments every cycle in REQ/RESP.
REQ-034 If TIMEOUT_CYC≠0 and the counter reaches TIMEOUT_CYC: pulse err for 1 cycle, return to IDLE, give no rvalid; the still-held request re-arbitrates.
REQ-035 mem_rvalid in IDLE or REQ SHALL be ignored.

Reset
REQ-036 rst low SHALL immediately force state=IDLE, owner=IF, last_owner=IF, counter=0, and all outputs to 0, independent of clk.
REQ-037 Reset asserted mid-transaction SHALL abandon it without an rvalid pulse; operation resumes on the first clk edge after rst rises.

Verification
REQ-038 Lone fetch: if_addr=0x80000004, mem_rdata=0x11223344_55667788, ready/rvalid immediate -> if_rdata=0x11223344, if_rvalid 1 cycle at cycle 2.
REQ-039 Tie after reset, FAIR=1: both request -> LS granted first, then IF; repeated ties alternate LS, IF, LS...; with FAIR=0 LS wins every tie.
REQ-040 Store: ls_we=1, ls_wmask=0x0F, ls_wdata=0xDEADBEEF -> mem_we=1, mem_wmask=0x0F held until mem_ready; ls_stall low the cycle mem_rvalid=1.
REQ-041 Timeout, TIMEOUT_CYC=4: mem_ready never asserted -> err pulse 4 cycles after REQ entry, no rvalid, request reissued.
REQ-042 rst low while in RESP -> mem_valid=0 and state IDLE at once; a late mem_rvalid produces no rvalid.

Source files
------------

// File: rtl/ysyx_22050243_mem_arb.sv
// ysyx_22050243_mem_arb: arbitrates instruction fetch and load/store onto a single memory port
module ysyx_22050243_mem_arb #(
  parameter int FAIR        = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_rvalid,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [63:0] ls_addr,
  input  logic [63:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic [63:0] ls_rdata,
  output logic        ls_rvalid,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        if_stall,
  output logic        ls_stall,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC - 1);
  state_t      state;
  logic        owner, last_owner;
  logic [15:0] cnt;
  logic        grant_ls, timeout, done;
  // owner/last_owner: 0 = fetch, 1 = load/store
  always_comb begin
    grant_ls  = ls_req & (~if_req | (FAIR == 0) | ~last_owner);
    timeout   = (TIMEOUT_CYC != 0) && (cnt == TO_LIM);
    done      = (state == RESP) & mem_rvalid;
    if_rvalid = done & ~owner;
    ls_rvalid = done & owner;
    if_rdata  = if_rvalid ? (mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0]) : '0;
    ls_rdata  = ls_rvalid ? mem_rdata : '0;
    if_stall  = rst & if_req & ~if_rvalid;
    ls_stall  = rst & ls_req & ~ls_rvalid;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b0;
      cnt        <= '0;
      err        <= 1'b0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: if (if_req | ls_req) begin
          state     <= REQ;
          mem_valid <= 1'b1;
          owner     <= grant_ls;
          cnt       <= '0;
          mem_we    <= grant_ls & ls_we;
          mem_addr  <= grant_ls ? ls_addr : if_addr;
          mem_wdata <= grant_ls ? ls_wdata : '0;
          mem_wmask <= grant_ls ? ls_wmask : '0;
        end
        REQ: begin
          cnt <= cnt + 16'd1;
          if (mem_ready) begin
            state      <= RESP;
            mem_valid  <= 1'b0;
            last_owner <= owner;
          end else if (timeout) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            err       <= 1'b1;
          end
        end
        RESP: begin
          cnt <= cnt + 16'd1;
          if (mem_rvalid) state <= IDLE;
          else if (timeout) begin
            state <= IDLE;
            err   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22050243_mem_arb.sv
// tb_ysyx_22050243_mem_arb: directed vector bench for the fetch/load-store memory arbiter
module tb_ysyx_22050243_mem_arb;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, if_req, ls_req, ls_we, mem_ready, mem_rvalid;
  logic [63:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [7:0]  ls_wmask;
  logic [31:0] a_if_rdata, b_if_rdata;
  logic [63:0] a_ls_rdata, b_ls_rdata, a_mem_addr, b_mem_addr, a_mem_wdata, b_mem_wdata;
  logic [7:0]  a_mem_wmask, b_mem_wmask;
  logic        a_if_rvalid, a_ls_rvalid, a_mem_valid, a_mem_we, a_if_stall, a_ls_stall, a_err;
  logic        b_if_rvalid, b_ls_rvalid, b_mem_valid, b_mem_we, b_if_stall, b_ls_stall, b_err;
  int checks = 0;
  int failures = 0;

  ysyx_22050243_mem_arb #(.FAIR(1), .TIMEOUT_CYC(4)) dut_a (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(a_if_rdata),
    .if_rvalid(a_if_rvalid), .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_wmask(ls_wmask), .ls_rdata(a_ls_rdata), .ls_rvalid(a_ls_rvalid),
    .mem_valid(a_mem_valid), .mem_ready(mem_ready), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .if_stall(a_if_stall), .ls_stall(a_ls_stall), .err(a_err));

  ysyx_22050243_mem_arb #(.FAIR(0), .TIMEOUT_CYC(0)) dut_b (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(b_if_rdata),
    .if_rvalid(b_if_rvalid), .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_wmask(ls_wmask), .ls_rdata(b_ls_rdata), .ls_rvalid(b_ls_rvalid),
    .mem_valid(b_mem_valid), .mem_ready(mem_ready), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .if_stall(b_if_stall), .ls_stall(b_ls_stall), .err(b_err));

  typedef struct {
    logic        ir;
    logic [63:0] ia;
    logic        lr;
    logic        we;
    logic [63:0] la;
    logic [63:0] wd;
    logic [7:0]  wm;
    logic [63:0] rd;
    logic        e_ls;
    logic [63:0] e_addr;
    logic        e_we;
    logic [63:0] e_wd;
    logic [7:0]  e_wm;
    logic [63:0] e_rd;
    logic        c_rd;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0;
    ls_wdata = '0; ls_wmask = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    @(posedge clk); #1;
    if_req = v.ir; if_addr = v.ia; ls_req = v.lr; ls_we = v.we; ls_addr = v.la;
    ls_wdata = v.wd; ls_wmask = v.wm; mem_rdata = v.rd; mem_ready = 1'b0; mem_rvalid = 1'b0;
    #1;
    chk($sformatf("v%0d_idle_valid", k), {63'b0, a_mem_valid}, 64'd0);
    chk($sformatf("v%0d_idle_stall", k), {63'b0, v.e_ls ? a_ls_stall : a_if_stall}, 64'd1);
    @(posedge clk); #1 mem_ready = 1'b1; #1;
    chk($sformatf("v%0d_req_valid", k), {63'b0, a_mem_valid}, 64'd1);
    chk($sformatf("v%0d_addr", k), a_mem_addr, v.e_addr);
    chk($sformatf("v%0d_we", k), {63'b0, a_mem_we}, {63'b0, v.e_we});
    chk($sformatf("v%0d_wdata", k), a_mem_wdata, v.e_wd);
    chk($sformatf("v%0d_wmask", k), {56'b0, a_mem_wmask}, {56'b0, v.e_wm});
    @(posedge clk); #1 mem_ready = 1'b0; mem_rvalid = 1'b1; #1;
    chk($sformatf("v%0d_resp_valid", k), {63'b0, a_mem_valid}, 64'd0);
    chk($sformatf("v%0d_rvalid", k), {63'b0, v.e_ls ? a_ls_rvalid : a_if_rvalid}, 64'd1);
    chk($sformatf("v%0d_other_rvalid", k), {63'b0, v.e_ls ? a_if_rvalid : a_ls_rvalid}, 64'd0);
    chk($sformatf("v%0d_stall_drop", k), {63'b0, v.e_ls ? a_ls_stall : a_if_stall}, 64'd0);
    if (v.c_rd) chk($sformatf("v%0d_rdata", k), v.e_ls ? a_ls_rdata : {32'b0, a_if_rdata}, v.e_rd);
    @(posedge clk); #1 mem_rvalid = 1'b0; if_req = 1'b0; ls_req = 1'b0; #1;
    chk($sformatf("v%0d_pulse_end", k), {63'b0, a_if_rvalid | a_ls_rvalid}, 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    idle_inputs();
    vecs[0] = '{1'b1, 64'h80000004, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 64'h1122334455667788,
                1'b0, 64'h80000004, 1'b0, 64'h0, 8'h00, 64'h11223344, 1'b1};
    vecs[1] = '{1'b1, 64'h80000010, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 64'h1122334455667788,
                1'b0, 64'h80000010, 1'b0, 64'h0, 8'h00, 64'h55667788, 1'b1};
    vecs[2] = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h80001008, 64'h0, 8'h00, 64'hcafef00d12345678,
                1'b1, 64'h80001008, 1'b0, 64'h0, 8'h00, 64'hcafef00d12345678, 1'b1};
    vecs[3] = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h80002000, 64'h00000000deadbeef, 8'h0f, 64'h0,
                1'b1, 64'h80002000, 1'b1, 64'h00000000deadbeef, 8'h0f, 64'h0, 1'b0};
    vecs[4] = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h80002008, 64'h0123456789abcdef, 8'hff, 64'hffffffffffffffff,
                1'b1, 64'h80002008, 1'b1, 64'h0123456789abcdef, 8'hff, 64'h0, 1'b0};
    vecs[5] = '{1'b1, 64'h80000008, 1'b0, 1'b1, 64'h999, 64'h5555, 8'haa, 64'haaaabbbbccccdddd,
                1'b0, 64'h80000008, 1'b0, 64'h0, 8'h00, 64'hccccdddd, 1'b1};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_valid", {63'b0, a_mem_valid}, 64'd0);
    chk("rst_mem_addr", a_mem_addr, 64'd0);
    chk("rst_err", {63'b0, a_err}, 64'd0);
    chk("rst_rvalid", {62'b0, a_if_rvalid, a_ls_rvalid}, 64'd0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
    // tie: both requests held, memory answers at minimum latency
    do_reset();
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 64'h100; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h200;
    mem_ready = 1'b1; mem_rvalid = 1'b1;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #2;
      if (a_mem_valid) begin
        chk($sformatf("tie_fair_%0d", n), a_mem_addr, n[0] ? 64'h100 : 64'h200);
        chk($sformatf("tie_fixed_%0d", n), b_mem_addr, 64'h200);
        n++;
      end
    end
    chk("tie_grants", 64'(n), 64'd4);
    // watchdog: memory never ready
    do_reset();
    @(posedge clk); #1 if_req = 1'b1; if_addr = 64'h40;
    @(posedge clk); #2 chk("to_req_valid", {63'b0, a_mem_valid}, 64'd1);
    @(posedge clk); #1 mem_rvalid = 1'b1; #1;
    chk("to_ignore_rvalid", {63'b0, a_if_rvalid}, 64'd0);
    @(posedge clk); #1 mem_rvalid = 1'b0;
    @(posedge clk); #2;
    chk("to_no_err_early", {63'b0, a_err}, 64'd0);
    @(posedge clk); #2;
    chk("to_err", {63'b0, a_err}, 64'd1);
    chk("to_valid_drop", {63'b0, a_mem_valid}, 64'd0);
    chk("to_no_rvalid", {63'b0, a_if_rvalid}, 64'd0);
    chk("to_stall_held", {63'b0, a_if_stall}, 64'd1);
    chk("to_disabled_valid", {63'b0, b_mem_valid}, 64'd1);
    chk("to_disabled_err", {63'b0, b_err}, 64'd0);
    @(posedge clk); #2;
    chk("to_err_pulse", {63'b0, a_err}, 64'd0);
    chk("to_reissue", {63'b0, a_mem_valid}, 64'd1);
    chk("to_reissue_addr", a_mem_addr, 64'h40);
    // reset asserted while waiting for the response
    do_reset();
    @(posedge clk); #1 ls_req = 1'b1; ls_addr = 64'h300; mem_rdata = 64'h77;
    @(posedge clk); #1 mem_ready = 1'b1;
    @(posedge clk); #1 mem_ready = 1'b0; #1 rst = 1'b0; #1;
    chk("mid_rst_valid", {63'b0, a_mem_valid}, 64'd0);
    chk("mid_rst_addr", a_mem_addr, 64'd0);
    mem_rvalid = 1'b1; #1;
    chk("mid_rst_late_rvalid", {63'b0, a_ls_rvalid}, 64'd0);
    @(posedge clk); #1 rst = 1'b1; #1;
    chk("post_rst_idle", {62'b0, a_ls_rvalid, a_mem_valid}, 64'd0);
    @(posedge clk); #2;
    chk("post_rst_resume", {63'b0, a_mem_valid}, 64'd1);
    chk("post_rst_no_rvalid", {63'b0, a_ls_rvalid}, 64'd0);
    idle_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
